ps2_device_tx: RTL and testbench
================================

Name: ps2_device_tx

Overview:
- PS/2 device-side (keyboard) transmitter; generates KEYSIG_CLK / KEYSIG_DATA waveforms carrying scan-code bytes.
- Drives the same PS/2 pins the Basys 3 top level receives on, so the keyboard receive path can be stimulated in simulation and on loopback.
- Accepts one byte at a time over a valid/ready handshake and emits one 11-bit frame per byte:
  - start bit 0
  - 8 data bits, LSB first
  - odd parity
  - stop bit 1

Parameters:
- CLK_HZ, 100000000, system clock frequency in Hz.
- PS2_HZ, 12500, PS/2 clock frequency in Hz (legal range 10–16.7 kHz).
- GAP_BITS, 2, idle PS/2 bit-periods inserted after each frame (clock and data high).

Ports:
- clk  in  1  system clock; all logic is on its rising edge.
- reset  in  1  synchronous, active-high reset.
- tx_data  in  8  scan-code byte to send.
- tx_valid  in  1  tx_data is valid.
- tx_ready  out  1  block can accept a byte this cycle.
- KEYSIG_CLK  out  1  PS/2 clock; idle high.
- KEYSIG_DATA  out  1  PS/2 data; idle high.
- busy  out  1  frame or gap in progress.
- frame_done  out  1  one-cycle pulse when the stop-bit low phase ends.

Behaviour:
- Interface: one clock and one reset. Reset is synchronous and active-high. All outputs are registered.
- HALF = CLK_HZ/(2*PS2_HZ), integer division; 4000 at the defaults. HALF must be ≥2 (elaboration-time check).
- Reset values: KEYSIG_CLK=1, KEYSIG_DATA=1, tx_ready=1, busy=0, frame_done=0. The FSM returns to IDLE and any in-flight byte is dropped.
- Reset mid-frame: lines return high on the next cycle; no frame_done.
- FSM states: IDLE, HIGH, LOW, GAP (plus INHIBIT when the optional feature is enabled).
- IDLE:
  - tx_ready=1.
  - Accept on tx_valid && tx_ready.
  - At that clock edge, load an 11-bit shift register {1, ~^tx_data, tx_data, 0}, bit_idx=0, KEYSIG_DATA=0, busy=1, tx_ready=0, and go to HIGH.
- HIGH: KEYSIG_CLK=1 for HALF cycles, then go to LOW with KEYSIG_CLK=0.
- LOW: KEYSIG_CLK=0 for HALF cycles.
  - If bit_idx<10: bit_idx++, shift so KEYSIG_DATA takes the next bit, KEYSIG_CLK=1, go to HIGH.
  - If bit_idx==10: frame_done=1 for one cycle, KEYSIG_CLK=1, KEYSIG_DATA=1, go to GAP.
- Data changes only at the start of a high phase, giving HALF cycles of setup before each falling edge. The host samples on the falling edge.
- GAP: lines stay high for GAP_BITS*2*HALF cycles, then go to IDLE with busy=0 and tx_ready=1.
- Per frame: exactly 11 falling edges. Frame length is 22*HALF cycles, plus the gap.
- Parity: odd over data+parity. Examples:
  - 0x1C → parity 0
  - 0x00 → parity 1
  - 0xF0 → parity 1
  - 0xFF → parity 1
- tx_valid while busy is ignored: tx_ready=0 and no byte is queued. The source must hold its byte until accepted.
- Back-to-back: if tx_valid is already high when GAP ends, the accept occurs on the first IDLE cycle. The start bit therefore appears one cycle after tx_ready rises.
- Counters: the half-period counter is $clog2(HALF)+1 bits and restarts on every phase change. bit_idx is 4 bits and never exceeds 10.

Optional Feature:
- Macro: HOST_INHIBIT_EN.
- When defined, adds input port host_inhibit (1 bit), meaning the host is holding the clock line low.
  - IDLE/GAP with host_inhibit=1: tx_ready=0, no frame starts, and the GAP counter holds.
  - HIGH/LOW with bit_idx≤9 and host_inhibit=1: abort.
    - Next cycle: KEYSIG_CLK=1, KEYSIG_DATA=1, go to INHIBIT. The byte is retained; no frame_done.
    - INHIBIT: wait for host_inhibit=0, then a full GAP, then retransmit the retained byte from the start bit.
  - Inhibit during the stop bit (bit_idx==10): ignored; the frame completes normally.
- When undefined: no host_inhibit port and no INHIBIT state. Frames always complete.

Test Plan:
- CLK_HZ=1000, PS2_HZ=100 (HALF=5), GAP_BITS=2; send 0x1C. Sample KEYSIG_DATA on KEYSIG_CLK falling edges → 0,0,0,1,1,1,0,0,0,0,1 (start, LSB-first data, parity 0, stop). Expect 11 falling edges, frame_done 110 cycles after accept, busy low 20 cycles later.
- Send 0x00, then 0xFF. Parity bits = 1 and 1; stop=1 for both.
- tx_valid held high with 0xF0 then 0x1C. Expect two frames with exactly 20 idle-high cycles between them. tx_ready is low throughout the frames and high exactly on the accept cycles. Pulsing a different byte while busy produces no extra frame.
- Assert reset at the 4th falling edge of a 0x55 frame. The next cycle shows KEYSIG_CLK=1, KEYSIG_DATA=1, tx_ready=1, busy=0, with no frame_done and no further edges.
- HOST_INHIBIT_EN defined: assert host_inhibit for 30 cycles after the 5th falling edge of 0xAA. The lines go high and the frame is aborted. 20 cycles after release, the full 0xAA frame is retransmitted with 11 edges and a single frame_done.
- HOST_INHIBIT_EN defined: host_inhibit high in IDLE with tx_valid=1. tx_ready stays 0 and the lines stay high; the frame starts one cycle after release.

Source files
------------

// File: rtl/ps2_device_tx.sv
// PS/2 device-side transmitter: turns accepted bytes into 11-bit keyboard frames on KEYSIG_CLK/KEYSIG_DATA.
// Define HOST_INHIBIT_EN to add the host_inhibit input (abort, wait, retransmit).
module ps2_device_tx #(
  parameter int CLK_HZ   = 100000000,
  parameter int PS2_HZ   = 12500,
  parameter int GAP_BITS = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
`ifdef HOST_INHIBIT_EN
  input  logic       host_inhibit,
`endif
  output logic       tx_ready,
  output logic       KEYSIG_CLK,
  output logic       KEYSIG_DATA,
  output logic       busy,
  output logic       frame_done
);

  localparam int HALF       = CLK_HZ / (2 * PS2_HZ);
  localparam int CW         = $clog2(HALF) + 1;
  localparam int GAP_HALVES = 2 * GAP_BITS;
  localparam int GW         = $clog2(GAP_HALVES + 1) + 1;

  localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_HALVES - 1);
  localparam logic [GW-1:0] GAP_ONE   = GW'(1);
  localparam logic [3:0]    STOP_IDX  = 4'd10;

  generate
    if (HALF < 2) begin : g_half_check
      $error("ps2_device_tx: CLK_HZ/(2*PS2_HZ) must be at least 2");
    end
    if (GAP_BITS < 1) begin : g_gap_check
      $error("ps2_device_tx: GAP_BITS must be at least 1");
    end
  endgenerate

  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

  // Wire order is bit 0 first: start, data LSB..MSB, parity, stop.
  function automatic logic [10:0] frame_bits(input logic [7:0] d);
    return {1'b1, odd_parity(d), d, 1'b0};
  endfunction

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    HIGH    = 3'd1,
    LOW     = 3'd2,
`ifdef HOST_INHIBIT_EN
    INHIBIT = 3'd4,
`endif
    GAP     = 3'd3
  } state_t;

  state_t         state_r, state_s;
  logic [CW-1:0]  cnt_r, cnt_s;
  logic [GW-1:0]  gap_r, gap_s;
  logic [3:0]     bit_idx_r, bit_idx_s;
  logic [10:0]    shift_r, shift_s;
  logic           clk_r, clk_s;
  logic           data_r, data_s;
  logic           ready_r, ready_s;
  logic           busy_r, busy_s;
  logic           done_r, done_s;
  logic           hold_s;

`ifdef HOST_INHIBIT_EN
  logic [7:0]     byte_r, byte_s;
  logic           retx_r, retx_s;
  logic           abort_s;
  assign hold_s  = host_inhibit;
  // The stop bit is never aborted; the frame is committed by then.
  assign abort_s = host_inhibit && (bit_idx_r != STOP_IDX);
`else
  assign hold_s  = 1'b0;
`endif

  assign tx_ready    = ready_r;
  assign KEYSIG_CLK  = clk_r;
  assign KEYSIG_DATA = data_r;
  assign busy        = busy_r;
  assign frame_done  = done_r;

  // Next-state and next-output logic for the frame sequencer.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    gap_s     = gap_r;
    bit_idx_s = bit_idx_r;
    shift_s   = shift_r;
    clk_s     = clk_r;
    data_s    = data_r;
    ready_s   = ready_r;
    busy_s    = busy_r;
    done_s    = 1'b0;
`ifdef HOST_INHIBIT_EN
    byte_s    = byte_r;
    retx_s    = retx_r;
`endif
    case (state_r)
      IDLE: begin
        if (tx_valid && !hold_s) begin
          state_s   = HIGH;
          cnt_s     = '0;
          bit_idx_s = 4'd0;
          shift_s   = frame_bits(tx_data);
          clk_s     = 1'b1;
          data_s    = 1'b0;
          busy_s    = 1'b1;
          ready_s   = 1'b0;
`ifdef HOST_INHIBIT_EN
          byte_s    = tx_data;
          retx_s    = 1'b0;
`endif
        end else begin
          ready_s = !hold_s;
        end
      end
      HIGH: begin
`ifdef HOST_INHIBIT_EN
        if (abort_s) begin
          state_s = INHIBIT;
          cnt_s   = '0;
          clk_s   = 1'b1;
          data_s  = 1'b1;
          retx_s  = 1'b1;
        end else
`endif
        if (cnt_r == HALF_LAST) begin
          state_s = LOW;
          cnt_s   = '0;
          clk_s   = 1'b0;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      LOW: begin
`ifdef HOST_INHIBIT_EN
        if (abort_s) begin
          state_s = INHIBIT;
          cnt_s   = '0;
          clk_s   = 1'b1;
          data_s  = 1'b1;
          retx_s  = 1'b1;
        end else
`endif
        if (cnt_r == HALF_LAST) begin
          cnt_s = '0;
          clk_s = 1'b1;
          if (bit_idx_r != STOP_IDX) begin
            // Data moves only as the clock rises, giving a full half period of setup.
            state_s   = HIGH;
            bit_idx_s = bit_idx_r + 4'd1;
            shift_s   = {1'b1, shift_r[10:1]};
            data_s    = shift_r[1];
          end else begin
            state_s = GAP;
            gap_s   = '0;
            data_s  = 1'b1;
            done_s  = 1'b1;
          end
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      GAP: begin
        if (hold_s) begin
          cnt_s = cnt_r;
        end else if (cnt_r == HALF_LAST) begin
          cnt_s = '0;
          if (gap_r == GAP_LAST) begin
`ifdef HOST_INHIBIT_EN
            if (retx_r) begin
              state_s   = HIGH;
              bit_idx_s = 4'd0;
              shift_s   = frame_bits(byte_r);
              clk_s     = 1'b1;
              data_s    = 1'b0;
              retx_s    = 1'b0;
            end else
`endif
            begin
              state_s = IDLE;
              busy_s  = 1'b0;
              ready_s = 1'b1;
            end
          end else begin
            gap_s = gap_r + GAP_ONE;
          end
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
`ifdef HOST_INHIBIT_EN
      INHIBIT: begin
        if (!hold_s) begin
          state_s = GAP;
          cnt_s   = '0;
          gap_s   = '0;
        end else begin
          cnt_s = '0;
        end
      end
`endif
      default: begin
        state_s = IDLE;
        cnt_s   = '0;
        clk_s   = 1'b1;
        data_s  = 1'b1;
        busy_s  = 1'b0;
        ready_s = 1'b1;
      end
    endcase
  end

  // State and output registers; reset drops any in-flight byte.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= IDLE;
      cnt_r     <= '0;
      gap_r     <= '0;
      bit_idx_r <= 4'd0;
      shift_r   <= 11'h7FF;
      clk_r     <= 1'b1;
      data_r    <= 1'b1;
      ready_r   <= 1'b1;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
`ifdef HOST_INHIBIT_EN
      byte_r    <= 8'h00;
      retx_r    <= 1'b0;
`endif
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      gap_r     <= gap_s;
      bit_idx_r <= bit_idx_s;
      shift_r   <= shift_s;
      clk_r     <= clk_s;
      data_r    <= data_s;
      ready_r   <= ready_s;
      busy_r    <= busy_s;
      done_r    <= done_s;
`ifdef HOST_INHIBIT_EN
      byte_r    <= byte_s;
      retx_r    <= retx_s;
`endif
    end
  end

endmodule

// File: tb/tb_ps2_device_tx.sv
// Self-checking bench for ps2_device_tx at HALF=5: table vectors, random bytes, and corner sequences.
module tb_ps2_device_tx;
  localparam int CLK_HZ   = 1000;
  localparam int PS2_HZ   = 100;
  localparam int GAP_BITS = 2;
  localparam int H        = CLK_HZ / (2 * PS2_HZ);
  localparam int GAPC     = GAP_BITS * 2 * H;
  localparam int FRAME    = 22 * H;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       KEYSIG_CLK;
  logic       KEYSIG_DATA;
  logic       busy;
  logic       frame_done;
`ifdef HOST_INHIBIT_EN
  logic       host_inhibit;
`endif

  int vectors = 0;
  int miscompares = 0;

  // Event log kept by the monitor only; tests remember base indices.
  int   cyc = 0;
  int   edge_cyc[$];
  logic edge_bit[$];
  int   done_cyc[$];
  int   busyfall_cyc[$];
  int   readyrise_cyc[$];
  int   ready_hi_cnt = 0;
  logic prev_clk = 1'b1;
  logic prev_busy = 1'b0;
  logic prev_ready = 1'b1;

  typedef struct {
    logic [7:0] b;
    logic       par;
  } vec_t;
  vec_t tbl[8];

  ps2_device_tx #(.CLK_HZ(CLK_HZ), .PS2_HZ(PS2_HZ), .GAP_BITS(GAP_BITS)) dut (
    .clk(clk),
    .reset(reset),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
`ifdef HOST_INHIBIT_EN
    .host_inhibit(host_inhibit),
`endif
    .tx_ready(tx_ready),
    .KEYSIG_CLK(KEYSIG_CLK),
    .KEYSIG_DATA(KEYSIG_DATA),
    .busy(busy),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Sample every cycle on the falling system-clock edge; sample label is cyc+1.
  always @(negedge clk) begin
    if (prev_clk && !KEYSIG_CLK) begin
      edge_cyc.push_back(cyc + 1);
      edge_bit.push_back(KEYSIG_DATA);
    end
    if (frame_done) done_cyc.push_back(cyc + 1);
    if (prev_busy && !busy) busyfall_cyc.push_back(cyc + 1);
    if (!prev_ready && tx_ready) readyrise_cyc.push_back(cyc + 1);
    if (tx_ready) ready_hi_cnt <= ready_hi_cnt + 1;
    prev_clk   <= KEYSIG_CLK;
    prev_busy  <= busy;
    prev_ready <= tx_ready;
    cyc        <= cyc + 1;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  // Wire bit k of a frame: start 0, data LSB first, odd parity, stop 1.
  function automatic int model_bit(input int b, input int k);
    int ones = 0;
    if (k == 0) return 0;
    if (k <= 8) return (b >> (k - 1)) & 1;
    if (k == 10) return 1;
    for (int i = 0; i < 8; i++) ones += (b >> i) & 1;
    return (ones % 2 == 0) ? 1 : 0;
  endfunction

  task automatic wait_ready();
    int waited = 0;
    while (tx_ready !== 1'b1 && waited < 400) begin
      tick(1);
      waited++;
    end
    check("ready_wait_in_budget", (waited < 400) ? 1 : 0, 1);
  endtask

  // Presents a byte for one accept; a is the label of the first post-accept sample.
  task automatic send(input logic [7:0] b, output int a);
    wait_ready();
    tx_data  = b;
    tx_valid = 1'b1;
    tick(1);
    tx_valid = 1'b0;
    a = cyc;
  endtask

  task automatic check_frame(input int a, input int b, input int eb, input int db, input int bb);
    check($sformatf("frame_edges_b%02h", b), (edge_cyc.size() >= eb + 11) ? 11 : edge_cyc.size() - eb, 11);
    if (edge_cyc.size() >= eb + 11) begin
      for (int k = 0; k < 11; k++) begin
        check($sformatf("edge%0d_time_b%02h", k, b), edge_cyc[eb + k] - a, H + 2 * H * k);
        check($sformatf("edge%0d_bit_b%02h", k, b), int'(edge_bit[eb + k]), model_bit(b, k));
      end
    end
    check("frame_done_present", (done_cyc.size() > db) ? 1 : 0, 1);
    if (done_cyc.size() > db) check("frame_done_time", done_cyc[db] - a, FRAME);
    check("busy_fall_present", (busyfall_cyc.size() > bb) ? 1 : 0, 1);
    if (busyfall_cyc.size() > bb) check("busy_fall_time", busyfall_cyc[bb] - a, FRAME + GAPC);
  endtask

  task automatic run_one(input logic [7:0] b);
    int a, eb, db, bb;
    eb = edge_cyc.size();
    db = done_cyc.size();
    bb = busyfall_cyc.size();
    send(b, a);
    check("start_data_low", KEYSIG_DATA, 0);
    check("start_busy", busy, 1);
    check("start_ready_low", tx_ready, 0);
    tick(FRAME + GAPC + 5);
    check("edges_per_frame", edge_cyc.size() - eb, 11);
    check("done_per_frame", done_cyc.size() - db, 1);
    check_frame(a, b, eb, db, bb);
  endtask

  initial begin
    int a, a2, r, eb, db, bb, rb, rh0, guard;
    tbl[0] = '{8'h1C, 1'b0};
    tbl[1] = '{8'h00, 1'b1};
    tbl[2] = '{8'hFF, 1'b1};
    tbl[3] = '{8'hF0, 1'b1};
    tbl[4] = '{8'h55, 1'b1};
    tbl[5] = '{8'h01, 1'b0};
    tbl[6] = '{8'h80, 1'b0};
    tbl[7] = '{8'h7F, 1'b0};

    reset    = 1'b1;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
`ifdef HOST_INHIBIT_EN
    host_inhibit = 1'b0;
`endif
    tick(3);
    check("reset_clk", KEYSIG_CLK, 1);
    check("reset_data", KEYSIG_DATA, 1);
    check("reset_ready", tx_ready, 1);
    check("reset_busy", busy, 0);
    check("reset_done", frame_done, 0);
    reset = 1'b0;
    tick(2);

    for (int i = 0; i < 8; i++) begin
      eb = edge_cyc.size();
      run_one(tbl[i].b);
      if (edge_cyc.size() >= eb + 11) begin
        check($sformatf("table_parity_b%02h", tbl[i].b), int'(edge_bit[eb + 9]), int'(tbl[i].par));
        check($sformatf("table_stop_b%02h", tbl[i].b), int'(edge_bit[eb + 10]), 1);
      end
    end

    for (int i = 0; i < 6; i++) begin
      tick($urandom_range(0, 7));
      run_one(8'($urandom_range(0, 255)));
    end

    // Back-to-back with tx_valid held, plus a stray pulse while busy.
    eb = edge_cyc.size();
    db = done_cyc.size();
    bb = busyfall_cyc.size();
    wait_ready();
    tx_data  = 8'hF0;
    tx_valid = 1'b1;
    tick(1);
    a   = cyc;
    rh0 = ready_hi_cnt;
    rb  = readyrise_cyc.size();
    tx_data = 8'h1C;
    guard = 0;
    while (readyrise_cyc.size() == rb && guard < 300) begin
      tick(1);
      guard++;
    end
    check("b2b_ready_rise_in_budget", (guard < 300) ? 1 : 0, 1);
    r = (readyrise_cyc.size() > rb) ? readyrise_cyc[rb] : cyc;
    check("b2b_ready_rise_time", r - a, FRAME + GAPC);
    if (done_cyc.size() > db) check("b2b_gap_cycles", r - done_cyc[db], GAPC);
    tick(1);
    a2 = cyc;
    check("b2b_start_next_cycle", KEYSIG_DATA, 0);
    check("b2b_ready_low_after_accept", tx_ready, 0);
    check("b2b_ready_high_samples", ready_hi_cnt - rh0, 1);
    tx_valid = 1'b0;
    tick(40);
    tx_data  = 8'h77;
    tx_valid = 1'b1;
    tick(1);
    tx_valid = 1'b0;
    tick(FRAME + GAPC + 60);
    check("b2b_total_edges", edge_cyc.size() - eb, 22);
    check("b2b_total_done", done_cyc.size() - db, 2);
    check("b2b_idle_after", busy, 0);
    check_frame(a, 8'hF0, eb, db, bb);
    check_frame(a2, 8'h1C, eb + 11, db + 1, bb + 1);

    // Reset at the fourth falling edge of a 0x55 frame.
    eb = edge_cyc.size();
    db = done_cyc.size();
    send(8'h55, a);
    guard = 0;
    while (edge_cyc.size() < eb + 4 && guard < 200) begin
      tick(1);
      guard++;
    end
    check("rst_mid_edge4_time", cyc - a, H + 2 * H * 3);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    check("rst_mid_clk", KEYSIG_CLK, 1);
    check("rst_mid_data", KEYSIG_DATA, 1);
    check("rst_mid_ready", tx_ready, 1);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_done", frame_done, 0);
    tick(FRAME + GAPC);
    check("rst_mid_no_more_edges", edge_cyc.size() - eb, 4);
    check("rst_mid_no_done", done_cyc.size() - db, 0);

`ifdef HOST_INHIBIT_EN
    // Inhibit after the fifth falling edge of 0xAA: abort, then full retransmit.
    eb = edge_cyc.size();
    db = done_cyc.size();
    bb = busyfall_cyc.size();
    send(8'hAA, a);
    guard = 0;
    while (edge_cyc.size() < eb + 5 && guard < 200) begin
      tick(1);
      guard++;
    end
    host_inhibit = 1'b1;
    tick(1);
    check("inh_abort_clk", KEYSIG_CLK, 1);
    check("inh_abort_data", KEYSIG_DATA, 1);
    check("inh_abort_busy", busy, 1);
    tick(29);
    check("inh_hold_edges", edge_cyc.size() - eb, 5);
    host_inhibit = 1'b0;
    r = cyc;
    tick(FRAME + 2 * GAPC + 10);
    check("inh_total_edges", edge_cyc.size() - eb, 16);
    check("inh_single_done", done_cyc.size() - db, 1);
    check_frame(r + 1 + GAPC, 8'hAA, eb + 5, db, bb);

    // Inhibit in IDLE holds off the start until release.
    eb = edge_cyc.size();
    db = done_cyc.size();
    bb = busyfall_cyc.size();
    host_inhibit = 1'b1;
    tick(2);
    tx_data  = 8'h12;
    tx_valid = 1'b1;
    tick(10);
    check("inh_idle_ready", tx_ready, 0);
    check("inh_idle_clk", KEYSIG_CLK, 1);
    check("inh_idle_data", KEYSIG_DATA, 1);
    check("inh_idle_no_edges", edge_cyc.size() - eb, 0);
    host_inhibit = 1'b0;
    tick(1);
    a = cyc;
    tx_valid = 1'b0;
    check("inh_idle_start", KEYSIG_DATA, 0);
    tick(FRAME + GAPC + 5);
    check_frame(a, 8'h12, eb, db, bb);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
